ahb_sram_slave: RTL and testbench

//  AHB-Lite slave that sits directly downstream of AHB_MASTER and consumes its HADDR/HTRANS/HWRITE/HSIZE/HWDATA.
//  It returns HREADYOUT/HRESP/HRDATA to the master.

---
 rtl/ahb_sram_slave_pkg.sv | 24 ++
 rtl/ahb_sram_slave_if.sv | 27 ++
 rtl/ahb_sram_slave_byte_lane_dec.sv | 21 ++
 rtl/ahb_sram_slave.sv | 121 ++++++++++++
 tb/tb_ahb_sram_slave.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and the slave state type for the SRAM slave.
package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_t;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between the master and the SRAM slave.
interface ahb_sram_slave_if;

  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

endinterface

// File: rtl/ahb_sram_slave_byte_lane_dec.sv
// Byte-lane write strobes from transfer size and the low address bits.
module ahb_sram_slave_byte_lane_dec
  import ahb_sram_slave_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] wstrb
);

  // Illegal sizes never reach a data phase, so they simply enable no lanes
  always_comb begin
    wstrb = 4'b0000;
    case (size)
      HSIZE_BYTE: wstrb = 4'b0001 << addr;
      HSIZE_HALF: wstrb = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: wstrb = 4'b1111;
      default:    wstrb = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory, programmable wait states,
// two-cycle ERROR response for out-of-window or misaligned transfers.
//   state   | meaning
//   IDLE    | no data phase in progress, ready for an address phase
//   WAIT    | OKAY data phase stretched by wait states
//   DATA    | final OKAY data cycle: write commits / read data driven
//   ERR1    | first ERROR cycle, hreadyout low
//   ERR2    | second ERROR cycle, hreadyout high
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h4000_0000,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic            hclk,
  input logic            hreset,
  ahb_sram_slave_if.slave bus
);

  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(MEM_DEPTH * 4);

  slave_state_t     state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q;
  logic [2:0]       size_q;
  logic             write_q;

  logic [31:0]      offset;
  logic             can_accept;
  logic             accept;
  logic             dec_err;
  logic [3:0]       wstrb;
  logic             unused_ok;

  logic [31:0]      mem [MEM_DEPTH];

  assign offset     = bus.haddr - ADDR_BASE;
  assign can_accept = state_q inside {ST_IDLE, ST_DATA, ST_ERR2};
  assign accept     = can_accept & bus.hsel & bus.hready & bus.htrans[1];
  assign unused_ok  = ^{bus.hburst, bus.hprot};

  // Address-phase error decision: window, illegal size, misalignment
  always_comb begin
    dec_err = 1'b0;
    if ((bus.haddr < ADDR_BASE) || (offset >= WIN_BYTES)) dec_err = 1'b1;
    if (bus.hsize > HSIZE_WORD) dec_err = 1'b1;
    if ((bus.hsize == HSIZE_HALF) && bus.haddr[0]) dec_err = 1'b1;
    if ((bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] != 2'b00)) dec_err = 1'b1;
  end

  // Next-state and wait-counter logic; IDLE, DATA and ERR2 all take new transfers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        if (accept) begin
          if (dec_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // State, counter and address-phase registers
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= HSIZE_WORD;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= offset[IDX_W+1:2];
        lane_q  <= bus.haddr[1:0];
        size_q  <= bus.hsize;
        write_q <= bus.hwrite;
      end
    end
  end

  ahb_sram_slave_byte_lane_dec u_lane_dec (
    .size  (size_q),
    .addr  (lane_q),
    .wstrb (wstrb)
  );

  // Commit enabled lanes at the end of a write DATA cycle; reset aborts it
  always_ff @(posedge hclk) begin
    if (!hreset && (state_q == ST_DATA) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign bus.hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign bus.hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata    = ((state_q == ST_DATA) && !write_q) ? mem[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (0, 2 and 3 wait states)
// share one master-side stimulus; only the selected instance sees hsel.
module tb_ahb_sram_slave;
  import ahb_sram_slave_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [1:0]  sel;

  logic        ready_o;
  logic [1:0]  resp_o;
  logic [31:0] rdata_o;

  always #5 hclk = ~hclk;

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus1 ();
  ahb_sram_slave_if bus2 ();

  assign bus0.hsel = hsel && (sel == 2'd0);
  assign bus0.haddr = haddr;
  assign bus0.htrans = htrans;
  assign bus0.hwrite = hwrite;
  assign bus0.hsize = hsize;
  assign bus0.hburst = 3'b000;
  assign bus0.hprot = 4'b0011;
  assign bus0.hwdata = hwdata;
  assign bus0.hready = bus0.hreadyout;

  assign bus1.hsel = hsel && (sel == 2'd1);
  assign bus1.haddr = haddr;
  assign bus1.htrans = htrans;
  assign bus1.hwrite = hwrite;
  assign bus1.hsize = hsize;
  assign bus1.hburst = 3'b000;
  assign bus1.hprot = 4'b0011;
  assign bus1.hwdata = hwdata;
  assign bus1.hready = bus1.hreadyout;

  assign bus2.hsel = hsel && (sel == 2'd2);
  assign bus2.haddr = haddr;
  assign bus2.htrans = htrans;
  assign bus2.hwrite = hwrite;
  assign bus2.hsize = hsize;
  assign bus2.hburst = 3'b000;
  assign bus2.hprot = 4'b0011;
  assign bus2.hwdata = hwdata;
  assign bus2.hready = bus2.hreadyout;

  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));
  ahb_sram_slave #(.WAIT_STATES(2)) dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1));
  ahb_sram_slave #(.WAIT_STATES(3)) dut2 (.hclk(hclk), .hreset(hreset), .bus(bus2));

  always_comb begin
    ready_o = bus0.hreadyout;
    resp_o  = bus0.hresp;
    rdata_o = bus0.hrdata;
    case (sel)
      2'd1: begin ready_o = bus1.hreadyout; resp_o = bus1.hresp; rdata_o = bus1.hrdata; end
      2'd2: begin ready_o = bus2.hreadyout; resp_o = bus2.hresp; rdata_o = bus2.hrdata; end
      default: ;
    endcase
  end

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic        in_data = 1'b0;
  int          low_cnt = 0;
  logic [1:0]  low_or = 2'b00;
  logic        acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Data-phase monitor: counts low cycles, pops the scoreboard when hreadyout rises
  initial begin
    forever begin
      @(negedge hclk);
      acc = hsel && ready_o && htrans[1];
      if (hreset) begin
        in_data = 1'b0;
        low_cnt = 0;
        low_or  = 2'b00;
      end else begin
        if (in_data) begin
          if (!ready_o) begin
            low_cnt++;
            low_or = low_or | resp_o;
          end else begin
            if (q.size() == 0) begin
              chk("scoreboard_empty", 32'(q.size()), 32'd1);
            end else begin
              cur = q.pop_front();
              chk({cur.tag, "_rdata"}, rdata_o, cur.data);
              chk({cur.tag, "_resp"}, 32'(resp_o), 32'(cur.resp));
              chk({cur.tag, "_waits"}, 32'(low_cnt), 32'(cur.waits));
              chk({cur.tag, "_lowresp"}, 32'(low_or), 32'(cur.resp));
            end
            in_data = 1'b0;
          end
        end
        if (acc) begin
          in_data = 1'b1;
          low_cnt = 0;
          low_or  = 2'b00;
        end
      end
    end
  end

  task automatic wait_ready(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge hclk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({tag, "_ready_timeout"}, 32'(ready_o), 32'd1);
    @(posedge hclk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [31:0] addr, input logic wr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic [1:0] exp_resp,
                       input int exp_waits);
    exp_t n;
    n.tag = tag; n.data = exp_data; n.resp = exp_resp; n.waits = exp_waits;
    q.push_back(n);
    hsel = 1'b1; haddr = addr; htrans = HTRANS_NONSEQ; hwrite = wr; hsize = size;
    wait_ready(tag);
    hwdata = wdata;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [2:0] size,
                    input logic [31:0] wdata, input logic [1:0] resp, input int waits);
    issue(tag, addr, 1'b1, size, wdata, 32'h0, resp, waits);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [2:0] size,
                    input logic [31:0] exp, input logic [1:0] resp, input int waits);
    issue(tag, addr, 1'b0, size, 32'h0, exp, resp, waits);
  endtask

  task automatic drain();
    hsel = 1'b0; htrans = HTRANS_IDLE;
    wait_ready("drain");
    hwdata = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1; hsel = 1'b0; haddr = 32'h0; htrans = HTRANS_IDLE;
    hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = 32'h0; sel = 2'd0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_resp", 32'(resp_o), 32'(HRESP_OKAY));
    chk("reset_rdata", rdata_o, 32'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    // zero wait states: basic write/read
    wr("t1_wr", 32'h4000_0000, HSIZE_WORD, 32'hA5A5_A5A5, HRESP_OKAY, 0);
    rd("t1_rd", 32'h4000_0000, HSIZE_WORD, 32'hA5A5_A5A5, HRESP_OKAY, 0);
    drain();

    // sub-word writes with lane-placed data
    wr("t3_clr", 32'h4000_0000, HSIZE_WORD, 32'h0000_0000, HRESP_OKAY, 0);
    wr("t3_byte", 32'h4000_0001, HSIZE_BYTE, 32'h0000_5A00, HRESP_OKAY, 0);
    wr("t3_half", 32'h4000_0002, HSIZE_HALF, 32'h1234_0000, HRESP_OKAY, 0);
    rd("t3_rd", 32'h4000_0000, HSIZE_WORD, 32'h1234_5A00, HRESP_OKAY, 0);
    drain();

    // error responses, memory untouched afterwards
    rd("t4_oow", 32'h4000_1000, HSIZE_WORD, 32'h0, HRESP_ERROR, 1);
    wr("t4_misal", 32'h4000_0002, HSIZE_WORD, 32'hFFFF_FFFF, HRESP_ERROR, 1);
    rd("t4_size", 32'h4000_0000, 3'b011, 32'h0, HRESP_ERROR, 1);
    wr("t4_halfodd", 32'h4000_0005, HSIZE_HALF, 32'hFFFF_FFFF, HRESP_ERROR, 1);
    rd("t4_below", 32'h3FFF_FFFC, HSIZE_WORD, 32'h0, HRESP_ERROR, 1);
    rd("t4_keep", 32'h4000_0000, HSIZE_WORD, 32'h1234_5A00, HRESP_OKAY, 0);
    drain();

    // last word of the window
    wr("top_wr", 32'h4000_0FFC, HSIZE_WORD, 32'h0F0F_F0F0, HRESP_OKAY, 0);
    rd("top_rd", 32'h4000_0FFC, HSIZE_WORD, 32'h0F0F_F0F0, HRESP_OKAY, 0);
    drain();

    // back-to-back write then read of the same word
    wr("t5_wr", 32'h4000_0008, HSIZE_WORD, 32'h1111_1111, HRESP_OKAY, 0);
    rd("t5_rd", 32'h4000_0008, HSIZE_WORD, 32'h1111_1111, HRESP_OKAY, 0);
    drain();

    // BUSY and unselected NONSEQ must not start a transfer
    wr("nt_init", 32'h4000_0010, HSIZE_WORD, 32'h7777_7777, HRESP_OKAY, 0);
    drain();
    hsel = 1'b1; haddr = 32'h4000_0010; htrans = HTRANS_BUSY; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge hclk); #1;
    hwdata = 32'hDEAD_DEAD;
    hsel = 1'b0; htrans = HTRANS_NONSEQ;
    @(posedge hclk); #1;
    hwdata = 32'hBAD0_BAD0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    @(negedge hclk);
    chk("nt_ready", 32'(ready_o), 32'd1);
    chk("nt_resp", 32'(resp_o), 32'(HRESP_OKAY));
    @(posedge hclk); #1;
    rd("nt_rd", 32'h4000_0010, HSIZE_WORD, 32'h7777_7777, HRESP_OKAY, 0);
    wr("lane3", 32'h4000_0013, HSIZE_BYTE, 32'hAB00_0000, HRESP_OKAY, 0);
    wr("lane10", 32'h4000_0010, HSIZE_HALF, 32'h0000_BEEF, HRESP_OKAY, 0);
    rd("lane_rd", 32'h4000_0010, HSIZE_WORD, 32'hAB77_BEEF, HRESP_OKAY, 0);
    drain();

    // two wait states
    sel = 2'd1;
    wr("t2_wr", 32'h4000_0004, HSIZE_WORD, 32'hDEAD_BEEF, HRESP_OKAY, 2);
    rd("t2_rd", 32'h4000_0004, HSIZE_WORD, 32'hDEAD_BEEF, HRESP_OKAY, 2);
    rd("t2_err", 32'h4000_1000, HSIZE_WORD, 32'h0, HRESP_ERROR, 1);
    drain();

    // three wait states, reset in the second wait cycle of a write
    sel = 2'd2;
    wr("t6_init", 32'h4000_000C, HSIZE_WORD, 32'h1357_2468, HRESP_OKAY, 3);
    drain();
    hsel = 1'b1; haddr = 32'h4000_000C; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
    wait_ready("t6_addr");
    hwdata = 32'hCAFE_F00D;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("t6_in_wait", 32'(ready_o), 32'd0);
    #1 hreset = 1'b1;
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("t6_rst_ready", 32'(ready_o), 32'd1);
    chk("t6_rst_resp", 32'(resp_o), 32'(HRESP_OKAY));
    @(posedge hclk); #1;
    hreset = 1'b0;
    hwdata = 32'h0;
    rd("t6_keep", 32'h4000_000C, HSIZE_WORD, 32'h1357_2468, HRESP_OKAY, 3);
    drain();

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
